// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types, segment glyphs and helpers for countdown_display
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_U     = 7'b1000001;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic int refresh_div(input int clock, input int hz);
        int d;
        d = clock / (hz * 4);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/countdown_display_bin2bcd.sv
// rtl/countdown_display_bin2bcd.sv - 7-bit sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state, next_state;
    logic [18:0] sr;
    logic [2:0]  iter;

    // One double-dabble step: correct each BCD nibble, then shift in the next binary bit
    function automatic logic [18:0] dabble(input logic [18:0] v);
        logic [18:0] t;
        t = v;
        if (t[18:15] >= 4'd5) t[18:15] = t[18:15] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        return {t[17:0], 1'b0};
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (iter == 3'd6) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr   <= {12'd0, value};
                        iter <= '0;
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr   <= dabble(sr);
                    iter <= iter + 3'd1;
                end
                DONE: begin
                    hundreds <= sr[18:15];
                    tens     <= sr[14:11];
                    ones     <= sr[10:7];
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/countdown_display.sv
// rtl/countdown_display.sv - 4-digit multiplexed 7-segment front end; COUNTDOWN_BLINK_EN adds 2 Hz blink
module countdown_display
    import countdown_pkg::*;
#(
    parameter int CLOCK      = 50000000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] current,
    input  logic       win,
    input  logic       lose,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       busy
);

    localparam int REFRESH_DIV = refresh_div(CLOCK, REFRESH_HZ);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [6:0] last_val;
    logic       force_conv;
    logic       start;
    logic       conv_done;
    logic [3:0] hundreds, tens, ones;

    // Changes arriving while busy are held off here and picked up once IDLE returns
    assign start = force_conv || (current != last_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_val   <= '0;
            force_conv <= 1'b1;
        end else if (start && !busy) begin
            last_val   <= current;
            force_conv <= 1'b0;
        end
    end

    bin2bcd_seq u_conv (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (current),
        .busy     (busy),
        .done     (conv_done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    logic blank_num;

`ifdef COUNTDOWN_BLINK_EN
    localparam int BLINK_DIV = (CLOCK / 4 < 1) ? 1 : CLOCK / 4;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk) begin
        if (reset || (!win && !lose)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank_num = (win || lose) && blink_phase;
`else
    assign blank_num = 1'b0;
`endif

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [1:0]    nidx;
    logic [6:0]    next_seg;

    assign nidx = idx + 2'd1;

    // Content is computed for the digit being switched to, so an and seg change together
    always_comb begin
        next_seg = SEG_BLANK;
        case (nidx)
            2'd0: next_seg = digit_to_seg(ones);
            2'd1: next_seg = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_to_seg(tens);
            2'd2: next_seg = (hundreds == 4'd0) ? SEG_BLANK : digit_to_seg(hundreds);
            2'd3: next_seg = lose ? SEG_L : (win ? SEG_U : SEG_BLANK);
            default: next_seg = SEG_BLANK;
        endcase
        if (blank_num && nidx != 2'd3) next_seg = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= nidx;
            an          <= ~(4'b0001 << nidx);
            seg         <= next_seg;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// tb/tb_countdown_display.sv - directed self-checking bench for countdown_display
module tb_countdown_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] current;
    logic       win, lose;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [6:0] scan_seg [4];
    logic [3:0] seen;

    localparam logic [6:0] BLANK = 7'b1111111;

    countdown_display #(.CLOCK(400), .REFRESH_HZ(25)) dut (
        .clk     (clk),
        .reset   (reset),
        .current (current),
        .win     (win),
        .lose    (lose),
        .an      (an),
        .seg     (seg),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scan();
        seen = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            case (an)
                4'b1110: begin scan_seg[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin scan_seg[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin scan_seg[2] = seg; seen[2] = 1'b1; end
                4'b0111: begin scan_seg[3] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        check("scan_all_digits", {28'd0, seen}, 32'hF);
    endtask

    int blank_n, shown_n, bad_status, bad_steady;

    initial begin
        reset = 1'b1; current = 7'd0; win = 1'b0; lose = 1'b0;
        tick(2);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, BLANK);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("init_busy_high", busy, 1'b1);
        end
        tick(1);
        check("init_busy_low", busy, 1'b0);
        scan();
        check("zero_idx0", scan_seg[0], 7'b1000000);
        check("zero_idx1", scan_seg[1], BLANK);
        check("zero_idx2", scan_seg[2], BLANK);
        check("zero_idx3", scan_seg[3], BLANK);

        // 42: registered BCD must change on exactly the 9th edge
        current = 7'd42;
        tick(8);
        check("c42_busy_8", busy, 1'b1);
        check("c42_ones_8", dut.ones, 4'd0);
        tick(1);
        check("c42_busy_9", busy, 1'b0);
        check("c42_ones_9", dut.ones, 4'd2);
        check("c42_tens_9", dut.tens, 4'd4);
        scan();
        check("c42_idx0", scan_seg[0], 7'b0100100);
        check("c42_idx1", scan_seg[1], 7'b0011001);
        check("c42_idx2", scan_seg[2], BLANK);

        // 127, then 5 during the third SHIFT cycle
        current = 7'd127;
        tick(3);
        current = 7'd5;
        tick(6);
        check("c127_busy", busy, 1'b0);
        check("c127_h", dut.hundreds, 4'd1);
        check("c127_t", dut.tens, 4'd2);
        check("c127_o", dut.ones, 4'd7);
        tick(1);
        check("c5_restart_busy", busy, 1'b1);
        tick(8);
        check("c5_busy_low", busy, 1'b0);
        check("c5_ones", dut.ones, 4'd5);
        scan();
        check("c5_idx0", scan_seg[0], 7'b0010010);
        check("c5_idx1", scan_seg[1], BLANK);
        check("c5_idx2", scan_seg[2], BLANK);

        // Status glyph priority
        current = 7'd0; lose = 1'b1;
        tick(12);
        scan();
        check("lose_idx3", scan_seg[3], 7'b1000111);
        check("lose_idx0", scan_seg[0], 7'b1000000);
        win = 1'b1; lose = 1'b0;
        scan();
        check("win_idx3", scan_seg[3], 7'b1000001);
        lose = 1'b1;
        scan();
        check("both_idx3", scan_seg[3], 7'b1000111);
        win = 1'b0; lose = 1'b0;

        // Reset in the middle of SHIFT
        current = 7'd99;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("mid_rst_an", an, 4'b1111);
        check("mid_rst_seg", seg, BLANK);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ones", dut.ones, 4'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("c99_restart_busy", busy, 1'b1);
        tick(8);
        check("c99_busy_low", busy, 1'b0);
        scan();
        check("c99_idx0", scan_seg[0], 7'b0010000);
        check("c99_idx1", scan_seg[1], 7'b0010000);
        check("c99_idx2", scan_seg[2], BLANK);
        check("c99_idx3", scan_seg[3], BLANK);

`ifdef COUNTDOWN_BLINK_EN
        win = 1'b1;
        blank_n = 0; shown_n = 0; bad_status = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if (an == 4'b1110 && seg == BLANK) blank_n++;
            if (an == 4'b1110 && seg == 7'b0010000) shown_n++;
            if (an == 4'b0111 && seg != 7'b1000001) bad_status++;
        end
        check("blink_has_blank", {31'd0, blank_n > 0}, 32'd1);
        check("blink_has_shown", {31'd0, shown_n > 0}, 32'd1);
        check("blink_status_steady", bad_status, 32'd0);
        win = 1'b0;
        tick(20);
        bad_steady = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (an == 4'b1110 && seg != 7'b0010000) bad_steady++;
        end
        check("blink_off_steady", bad_steady, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
